reg_file_multiport: RTL
=======================

Name: reg_file_multiport

Overview:
- Parametrised general-purpose register file for the next-generation core pipeline.
- Generalises the fixed three-read, one-write register file to NUM_READ registered read ports of configurable width and depth.
- Adds a per-register pending-write scoreboard for hazard detection.
- Adds a post-reset clearing sequencer, so storage may map onto RAM without a per-register reset.

Parameters:
DATA_W, 32, register data width in bits
NUM_REGS, 16, number of registers (power of two, >= 4)
SEL_W, $clog2(NUM_REGS), register select width
NUM_READ, 3, number of read ports (1..8)
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and locks

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
rd_sel  in  NUM_READ*SEL_W  read selects; port i occupies bits [i*SEL_W +: SEL_W]
rd_data  out  NUM_READ*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
rd_locked  out  NUM_READ  registered pending flag for each port's selected register
wr_en  in  1  write enable
wr_sel  in  SEL_W  write target
wr_data  in  DATA_W  write data
lock_en  in  1  mark lock_sel as pending (instruction issued with that destination)
lock_sel  in  SEL_W  register to lock
init_busy  out  1  high while the clearing sequencer runs; requests must be held off

Behaviour:
- Reset (rst=1 at an edge):
  - rd_data=0, rd_locked=0, all lock bits=0, init_busy=1, clear index=0, FSM=CLEAR.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes 0 to reg[idx], then idx increments.
  - When idx=NUM_REGS-1 is written, go to RUN next cycle; init_busy falls in that same cycle.
  - Total CLEAR duration is NUM_REGS cycles after rst deasserts.
  - wr_en and lock_en are ignored; rd_data and rd_locked are held at 0.
- Reset asserted mid-CLEAR or in RUN: restart CLEAR at idx=0.
- RUN, reads:
  - 1-cycle latency: rd_data[i] in cycle n+1 = reg[rd_sel[i]] sampled at edge n.
  - rd_locked[i] is also 1-cycle latency and reflects lock state after edge-n updates.
- RUN, write (wr_en=1):
  - reg[wr_sel] <= wr_data.
  - lock[wr_sel] <= 0 (writeback retires the producer).
- RUN, lock (lock_en=1): lock[lock_sel] <= 1.
- Simultaneous lock_en and wr_en to the same register: lock wins (bit ends at 1); the data write still occurs.
- ZERO_REG=1:
  - Reads of register 0 return 0 and rd_locked=0.
  - Writes and locks to register 0 are dropped.
- Multiple read ports selecting the same register return identical data.
- The register file performs no wrap or arithmetic on data; the select is fully decoded for all NUM_REGS values.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined:
  - A read whose rd_sel equals wr_sel while wr_en=1 in RUN returns wr_data at cycle n+1 (write-then-read).
  - ZERO_REG rules still apply.
- Undefined:
  - The same read returns the pre-write value.
  - The new value is visible from the next read onward.
- rd_locked is post-update in both builds.

Test Plan:
- Reset then idle, NUM_REGS=16:
  - init_busy=1 for exactly 16 cycles after rst falls.
  - Then reading all 16 regs returns 0x00000000 and rd_locked=0.
- Write during CLEAR: wr_en=1, wr_sel=5, wr_data=0xDEADBEEF at CLEAR cycle 3 -> ignored; after RUN, reg5 reads 0.
- Write and read in RUN:
  - Write reg7=0x12345678; next cycle rd_sel[0..2]=7,7,0 -> rd_data=0x12345678, 0x12345678, 0 one cycle later.
  - Write reg0=0xFFFFFFFF -> reads 0.
- Scoreboard:
  - lock_en on reg3 -> rd_locked for sel 3 is 1.
  - wr_en reg3=0xA5 -> rd_locked=0, data 0xA5.
  - Same-cycle lock and write reg4=0x11 -> locked=1, data 0x11.
- Bypass: wr_en reg9=0xCAFEF00D with rd_sel[1]=9 in the same cycle -> rd_data[1]=0xCAFEF00D next cycle with macro, previous value (0) without.
- Reset mid-operation: assert rst during CLEAR idx=10 and in RUN after writes -> CLEAR restarts at 0, all regs 0, all locks 0, init_busy=1 for 16 cycles.

Source files
------------

// File: rtl/reg_file_multiport.sv
// Multi-port register file with pending-write scoreboard and post-reset clearing sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_WRITE_BYPASS_EN.
module reg_file_multiport #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter int NUM_READ = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_READ*SEL_W-1:0]  rd_sel,
  output logic [NUM_READ*DATA_W-1:0] rd_data,
  output logic [NUM_READ-1:0]        rd_locked,
  input  logic                       wr_en,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       lock_en,
  input  logic [SEL_W-1:0]           lock_sel,
  output logic                       init_busy
);

`ifdef REG_FILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                     state_q, state_nx;
  logic [SEL_W-1:0]           clr_idx;
  logic [DATA_W-1:0]          mem [NUM_REGS];
  logic [NUM_REGS-1:0]        lock_q, lock_nx;
  logic                       wr_ok, lock_ok;
  logic [NUM_READ*DATA_W-1:0] rd_data_p0, rd_data_p1;
  logic [NUM_READ-1:0]        rd_locked_p0, rd_locked_p1;

  function automatic logic is_zero(input logic [SEL_W-1:0] s);
    return (ZERO_REG != 0) && (s == '0);
  endfunction

  assign wr_ok   = (state_q == RUN) && wr_en && !is_zero(wr_sel);
  assign lock_ok = (state_q == RUN) && lock_en && !is_zero(lock_sel);

  always_comb begin
    state_nx  = state_q;
    init_busy = 1'b0;
    case (state_q)
      CLEAR: begin
        init_busy = 1'b1;
        if (clr_idx == SEL_W'(NUM_REGS - 1)) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_idx <= '0;
    end else begin
      state_q <= state_nx;
      if (state_q == CLEAR) clr_idx <= clr_idx + SEL_W'(1);
    end
  end

  // Lock set is applied after the writeback clear so an issue wins over a retire.
  always_comb begin
    lock_nx = lock_q;
    if (wr_ok)   lock_nx[wr_sel]   = 1'b0;
    if (lock_ok) lock_nx[lock_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) lock_q <= '0;
    else     lock_q <= lock_nx;
  end

  // Storage carries no reset so it can map onto RAM; the sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) mem[clr_idx] <= '0;
      else if (wr_ok)       mem[wr_sel]  <= wr_data;
    end
  end

  // p0: read select decode and forwarding
  always_comb begin
    rd_data_p0   = '0;
    rd_locked_p0 = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      if ((state_q == RUN) && !is_zero(rd_sel[i*SEL_W +: SEL_W])) begin
        if (BYPASS && wr_ok && (wr_sel == rd_sel[i*SEL_W +: SEL_W]))
          rd_data_p0[i*DATA_W +: DATA_W] = wr_data;
        else
          rd_data_p0[i*DATA_W +: DATA_W] = mem[rd_sel[i*SEL_W +: SEL_W]];
        rd_locked_p0[i] = lock_nx[rd_sel[i*SEL_W +: SEL_W]];
      end
    end
  end

  // p1: registered read outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_p1   <= '0;
      rd_locked_p1 <= '0;
    end else begin
      rd_data_p1   <= rd_data_p0;
      rd_locked_p1 <= rd_locked_p0;
    end
  end

  assign rd_data   = rd_data_p1;
  assign rd_locked = rd_locked_p1;

endmodule
